crc8_serial: RTL

//  Bit-serial CRC-8 engine that consumes bytes and produces a running CRC.
//  It is the consumer stage of the xor_1b cell: every XOR in the datapath is an xor_1b instance.
//  The `^`/`~^` operators are not used anywhere in this block.

---
 rtl/crc8_pkg.sv | 18 +
 rtl/xor_1b.sv | 13 +
 rtl/crc8_serial.sv | 113 +++++++++++
 3 files changed

// File: rtl/crc8_pkg.sv
// Shared definitions for the bit-serial CRC-8 engine.
//   - FSM state encoding (IDLE/SHIFT/DONE; 2'd3 is unused and recovers to IDLE)
//   - default polynomial for CRC-8/SMBUS (x^8 + x^2 + x + 1, x^8 implicit)
package crc8_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [7:0] CRC8_POLY_SMBUS = 8'h07;

  typedef enum logic [1:0] {
    StIdle  = S_IDLE,
    StShift = S_SHIFT,
    StDone  = S_DONE
  } crc8_state_e;

endpackage

// File: rtl/xor_1b.sv
// Single-bit XOR cell.
// Ports:
//   a_i, b_i : operand bits
//   y_o      : a_i XOR b_i, built from AND/OR/NOT so the cell is self-contained
module xor_1b (
  input  logic a_i,
  input  logic b_i,
  output logic y_o
);

  assign y_o = (a_i & ~b_i) | (~a_i & b_i);

endmodule

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8 engine. Accepts one byte per valid/ready handshake, folds it into
// the running CRC MSB first at one bit per clock, then pulses crc_valid for one cycle.
// Every XOR in the datapath is an xor_1b instance.
// Ports:
//   clk       : clock, all state on rising edge
//   rst       : asynchronous active-high reset
//   clr       : synchronous clear, CRC <= INIT and any byte in flight is dropped
//   in_valid  : in_data holds a byte
//   in_ready  : engine accepts a byte this cycle
//   in_data   : byte to fold in, sampled only at transfer
//   crc_out   : running CRC register (no final XOR or reflection)
//   crc_valid : one-cycle pulse, crc_out includes the last accepted byte
//   busy      : a byte is being processed (SHIFT or DONE)
module crc8_serial
  import crc8_pkg::*;
#(
  parameter logic [7:0] POLY = CRC8_POLY_SMBUS,
  parameter logic [7:0] INIT = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic [7:0] crc_out,
  output logic       crc_valid,
  output logic       busy
);

  crc8_state_e state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  data_q, data_d;
  logic [7:0]  crc_q, crc_d;

  logic        fb;
  logic [7:0]  crc_shl;
  logic [7:0]  crc_step;

  // Feedback bit: CRC MSB combined with the current message bit.
  xor_1b u_xor_fb (
    .a_i (crc_q[7]),
    .b_i (data_q[cnt_q]),
    .y_o (fb)
  );

  assign crc_shl = {crc_q[6:0], 1'b0};

  // One cell per register bit; bits where POLY is 0 see a constant-0 operand.
  for (genvar i = 0; i < 8; i++) begin : g_xor_bit
    xor_1b u_xor_bit (
      .a_i (crc_shl[i]),
      .b_i (fb & POLY[i]),
      .y_o (crc_step[i])
    );
  end

  assign in_ready  = (state_q == StIdle) & ~clr & ~rst;
  assign crc_valid = (state_q == StDone);
  assign busy      = (state_q == StShift) | (state_q == StDone);
  assign crc_out   = crc_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    crc_d   = crc_q;
    if (clr) begin
      state_d = StIdle;
      cnt_d   = 3'd0;
      crc_d   = INIT;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid && in_ready) begin
            data_d  = in_data;
            cnt_d   = 3'd7;
            state_d = StShift;
          end
        end
        StShift: begin
          crc_d = crc_step;
          if (cnt_q == 3'd0) begin
            state_d = StDone;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        StDone: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 3'd0;
      data_q  <= 8'h00;
      crc_q   <= INIT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      crc_q   <= crc_d;
    end
  end

endmodule
